// File: rtl/apb2axi_read_resp_collector.sv
// AXI R-channel collector: buffers every read beat and emits one merged
// completion record per burst, both drained through independent pop ports.
module apb2axi_read_resp_collector #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int DATA_DEPTH = 16,
  parameter int CPL_DEPTH  = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  dat_valid,
  input  logic                  dat_ready,
  output logic [AXI_DATA_W-1:0] dat_data,
  output logic                  dat_last,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [AXI_ID_W-1:0]   cpl_id,
  output logic [4:0]            cpl_beats,
  output logic [1:0]            cpl_resp,
  output logic                  err_overrun
);

  localparam int DW  = AXI_DATA_W + 1;
  localparam int CW  = AXI_ID_W + 7;
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CAW = $clog2(CPL_DEPTH);
  localparam logic [DAW:0]   DAT_FULL    = (DAW+1)'(DATA_DEPTH);
  localparam logic [DAW:0]   DAT_CNT_ONE = (DAW+1)'(1);
  localparam logic [DAW-1:0] DAT_PTR_ONE = DAW'(1);
  localparam logic [CAW:0]   CPL_FULL    = (CAW+1)'(CPL_DEPTH);
  localparam logic [CAW:0]   CPL_CNT_ONE = (CAW+1)'(1);
  localparam logic [CAW-1:0] CPL_PTR_ONE = CAW'(1);

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic          rready_r, err_overrun_r;
  logic [4:0]    beat_cnt_r;
  logic [1:0]    resp_acc_r;
  logic          accept_s, last_eff_s, overrun_s;
  logic [1:0]    merged_s, cpl_resp_push_s;

  logic [DW-1:0]  dat_mem_r [DATA_DEPTH];
  logic [DAW-1:0] dat_wr_r, dat_rd_r, dat_rd_nxt_s;
  logic [DAW:0]   dat_cnt_r, dat_cnt_nxt_s;
  logic [DW-1:0]  dat_din_s, dat_head_r, dat_head_nxt_s;
  logic           dat_push_s, dat_pop_s, dat_valid_r, dat_full_nxt_s;

  logic [CW-1:0]  cpl_mem_r [CPL_DEPTH];
  logic [CAW-1:0] cpl_wr_r, cpl_rd_r, cpl_rd_nxt_s;
  logic [CAW:0]   cpl_cnt_r, cpl_cnt_nxt_s;
  logic [CW-1:0]  cpl_din_s, cpl_head_r, cpl_head_nxt_s;
  logic           cpl_push_s, cpl_pop_s, cpl_valid_r, cpl_full_nxt_s;

  // Burst bookkeeping: acceptance, 16-beat cap and response merge.
  always_comb begin
    accept_s   = rvalid && rready_r;
    last_eff_s = rlast || (beat_cnt_r == 5'd15);
    overrun_s  = (beat_cnt_r == 5'd15) && !rlast;
    merged_s   = resp_max(resp_acc_r, rresp);
    if (overrun_s && (merged_s != 2'b11)) begin
      cpl_resp_push_s = 2'b10;
    end else begin
      cpl_resp_push_s = merged_s;
    end
    dat_din_s = {rdata, last_eff_s};
    cpl_din_s = {rid, beat_cnt_r + 5'd1, cpl_resp_push_s};
  end

  // Burst state and the registered ready, computed from next-cycle occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rready_r      <= 1'b0;
      beat_cnt_r    <= 5'd0;
      resp_acc_r    <= 2'b00;
      err_overrun_r <= 1'b0;
    end else begin
      rready_r <= !(dat_full_nxt_s || cpl_full_nxt_s);
      if (accept_s) begin
        if (last_eff_s) begin
          beat_cnt_r <= 5'd0;
          resp_acc_r <= 2'b00;
        end else begin
          beat_cnt_r <= beat_cnt_r + 5'd1;
          resp_acc_r <= merged_s;
        end
        if (overrun_s) begin
          err_overrun_r <= 1'b1;
        end
      end
    end
  end

  // Beat FIFO next state; the head is pre-computed so outputs come from flops.
  always_comb begin
    dat_push_s   = accept_s && (dat_cnt_r != DAT_FULL);
    dat_pop_s    = dat_ready && dat_valid_r;
    dat_rd_nxt_s = dat_pop_s ? (dat_rd_r + DAT_PTR_ONE) : dat_rd_r;
    case ({dat_push_s, dat_pop_s})
      2'b10:   dat_cnt_nxt_s = dat_cnt_r + DAT_CNT_ONE;
      2'b01:   dat_cnt_nxt_s = dat_cnt_r - DAT_CNT_ONE;
      default: dat_cnt_nxt_s = dat_cnt_r;
    endcase
    // A push landing on the next read slot only happens when the FIFO drains to it.
    if (dat_push_s && (dat_wr_r == dat_rd_nxt_s)) begin
      dat_head_nxt_s = dat_din_s;
    end else if (dat_cnt_nxt_s == '0) begin
      dat_head_nxt_s = dat_head_r;
    end else begin
      dat_head_nxt_s = dat_mem_r[dat_rd_nxt_s];
    end
    dat_full_nxt_s = (dat_cnt_nxt_s == DAT_FULL);
  end

  // Beat FIFO pointers, occupancy and head register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dat_wr_r    <= '0;
      dat_rd_r    <= '0;
      dat_cnt_r   <= '0;
      dat_head_r  <= '0;
      dat_valid_r <= 1'b0;
    end else begin
      if (dat_push_s) begin
        dat_wr_r <= dat_wr_r + DAT_PTR_ONE;
      end
      dat_rd_r    <= dat_rd_nxt_s;
      dat_cnt_r   <= dat_cnt_nxt_s;
      dat_head_r  <= dat_head_nxt_s;
      dat_valid_r <= (dat_cnt_nxt_s != '0);
    end
  end

  // Beat FIFO storage.
  always_ff @(posedge aclk) begin
    if (dat_push_s) begin
      dat_mem_r[dat_wr_r] <= dat_din_s;
    end
  end

  // Completion FIFO next state, same scheme as the beat FIFO.
  always_comb begin
    cpl_push_s   = accept_s && last_eff_s && (cpl_cnt_r != CPL_FULL);
    cpl_pop_s    = cpl_ready && cpl_valid_r;
    cpl_rd_nxt_s = cpl_pop_s ? (cpl_rd_r + CPL_PTR_ONE) : cpl_rd_r;
    case ({cpl_push_s, cpl_pop_s})
      2'b10:   cpl_cnt_nxt_s = cpl_cnt_r + CPL_CNT_ONE;
      2'b01:   cpl_cnt_nxt_s = cpl_cnt_r - CPL_CNT_ONE;
      default: cpl_cnt_nxt_s = cpl_cnt_r;
    endcase
    if (cpl_push_s && (cpl_wr_r == cpl_rd_nxt_s)) begin
      cpl_head_nxt_s = cpl_din_s;
    end else if (cpl_cnt_nxt_s == '0) begin
      cpl_head_nxt_s = cpl_head_r;
    end else begin
      cpl_head_nxt_s = cpl_mem_r[cpl_rd_nxt_s];
    end
    cpl_full_nxt_s = (cpl_cnt_nxt_s == CPL_FULL);
  end

  // Completion FIFO pointers, occupancy and head register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cpl_wr_r    <= '0;
      cpl_rd_r    <= '0;
      cpl_cnt_r   <= '0;
      cpl_head_r  <= '0;
      cpl_valid_r <= 1'b0;
    end else begin
      if (cpl_push_s) begin
        cpl_wr_r <= cpl_wr_r + CPL_PTR_ONE;
      end
      cpl_rd_r    <= cpl_rd_nxt_s;
      cpl_cnt_r   <= cpl_cnt_nxt_s;
      cpl_head_r  <= cpl_head_nxt_s;
      cpl_valid_r <= (cpl_cnt_nxt_s != '0);
    end
  end

  // Completion FIFO storage.
  always_ff @(posedge aclk) begin
    if (cpl_push_s) begin
      cpl_mem_r[cpl_wr_r] <= cpl_din_s;
    end
  end

  assign rready      = rready_r;
  assign err_overrun = err_overrun_r;
  assign dat_valid   = dat_valid_r;
  assign dat_data    = dat_head_r[DW-1:1];
  assign dat_last    = dat_head_r[0];
  assign cpl_valid   = cpl_valid_r;
  assign {cpl_id, cpl_beats, cpl_resp} = cpl_head_r;

endmodule

// File: tb/tb_apb2axi_read_resp_collector.sv
// Directed bench for apb2axi_read_resp_collector: a per-cycle vector table
// plus hand sequences for overrun, FIFO-full and mid-burst reset behaviour.
module tb_apb2axi_read_resp_collector;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        dat_valid, dat_ready, dat_last;
  logic [31:0] dat_data;
  logic        cpl_valid, cpl_ready;
  logic [3:0]  cpl_id;
  logic [4:0]  cpl_beats;
  logic [1:0]  cpl_resp;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;

  apb2axi_read_resp_collector dut (
    .aclk(aclk), .aresetn(aresetn),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_last(dat_last),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id),
    .cpl_beats(cpl_beats), .cpl_resp(cpl_resp), .err_overrun(err_overrun)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        dat_ready;
    logic        cpl_ready;
    logic        e_rready;
    logic        e_dv;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_cv;
    logic [3:0]  e_id;
    logic [4:0]  e_beats;
    logic [1:0]  e_resp;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    rvalid = 1'b0; dat_ready = 1'b0; cpl_ready = 1'b0;
    #1;
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_dat_valid", {31'd0, dat_valid}, 32'd0);
    chk("rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
    chk("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d,
                           input logic [1:0] r, input logic l);
    rvalid = 1'b1; rid = id; rdata = d; rresp = r; rlast = l;
    for (int i = 0; i < 50 && !rready; i++) step();
    chk("send_ready", {31'd0, rready}, 32'd1);
    if (rready) step();
    rvalid = 1'b0;
  endtask

  initial begin
    logic [32:0] q[$];
    int          j;
    logic        acc, pop;

    rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0;
    rvalid = 1'b0; dat_ready = 1'b0; cpl_ready = 1'b0;

    //            rv    rid    rdata          rresp  rlast dr    cr    | rr    dv    data           last  cv    id     beats  resp
    vecs[0]  = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[1]  = '{1'b1, 4'd3, 32'hDEADBEEF,  2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF,  1'b1, 1'b1, 4'd3, 5'd1, 2'd0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[3]  = '{1'b1, 4'd5, 32'h11,        2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[4]  = '{1'b1, 4'd5, 32'h22,        2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[5]  = '{1'b1, 4'd5, 32'h33,        2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[6]  = '{1'b1, 4'd5, 32'h44,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,        1'b0, 1'b1, 4'd5, 5'd4, 2'd2};
    vecs[7]  = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22,        1'b0, 1'b1, 4'd5, 5'd4, 2'd2};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33,        1'b0, 1'b1, 4'd5, 5'd4, 2'd2};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44,        1'b1, 1'b1, 4'd5, 5'd4, 2'd2};
    vecs[10] = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'd5, 5'd4, 2'd2};
    vecs[11] = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 5'd0, 2'd0};
    vecs[12] = '{1'b1, 4'd1, 32'hA1,        2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1,        1'b1, 1'b1, 4'd1, 5'd1, 2'd1};
    vecs[13] = '{1'b1, 4'd2, 32'hA2,        2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1,        1'b1, 1'b1, 4'd1, 5'd1, 2'd1};
    vecs[14] = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA2,        1'b1, 1'b1, 4'd2, 5'd1, 2'd3};
    vecs[15] = '{1'b0, 4'd0, 32'h0,         2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 5'd0, 2'd0};

    // Reset values
    do_reset();
    chk("post_rst_rready", {31'd0, rready}, 32'd1);
    chk("post_rst_dat_data", dat_data, 32'd0);
    chk("post_rst_dat_last", {31'd0, dat_last}, 32'd0);
    chk("post_rst_cpl_id", {28'd0, cpl_id}, 32'd0);
    chk("post_rst_cpl_beats", {27'd0, cpl_beats}, 32'd0);
    chk("post_rst_cpl_resp", {30'd0, cpl_resp}, 32'd0);

    // Per-cycle vector table
    for (int i = 0; i < 16; i++) begin
      rvalid = vecs[i].rvalid; rid = vecs[i].rid; rdata = vecs[i].rdata;
      rresp = vecs[i].rresp; rlast = vecs[i].rlast;
      dat_ready = vecs[i].dat_ready; cpl_ready = vecs[i].cpl_ready;
      step();
      chk($sformatf("v%0d_rready", i), {31'd0, rready}, {31'd0, vecs[i].e_rready});
      chk($sformatf("v%0d_dat_valid", i), {31'd0, dat_valid}, {31'd0, vecs[i].e_dv});
      chk($sformatf("v%0d_cpl_valid", i), {31'd0, cpl_valid}, {31'd0, vecs[i].e_cv});
      if (vecs[i].e_dv) begin
        chk($sformatf("v%0d_dat_data", i), dat_data, vecs[i].e_data);
        chk($sformatf("v%0d_dat_last", i), {31'd0, dat_last}, {31'd0, vecs[i].e_last});
      end
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_cpl_id", i), {28'd0, cpl_id}, {28'd0, vecs[i].e_id});
        chk($sformatf("v%0d_cpl_beats", i), {27'd0, cpl_beats}, {27'd0, vecs[i].e_beats});
        chk($sformatf("v%0d_cpl_resp", i), {30'd0, cpl_resp}, {30'd0, vecs[i].e_resp});
      end
    end
    rvalid = 1'b0; dat_ready = 1'b0; cpl_ready = 1'b0;

    // 17 beats with rlast only on the 17th: forced split at 16
    do_reset();
    dat_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      send_beat(4'd7, 32'h100 + 32'(k), 2'd0, (k == 17));
      if (k == 16) begin
        chk("ovr_dat_data16", dat_data, 32'h110);
        chk("ovr_dat_last16", {31'd0, dat_last}, 32'd1);
        chk("ovr_cpl_valid", {31'd0, cpl_valid}, 32'd1);
        chk("ovr_cpl_beats", {27'd0, cpl_beats}, 32'd16);
        chk("ovr_cpl_resp", {30'd0, cpl_resp}, 32'd2);
        chk("ovr_cpl_id", {28'd0, cpl_id}, 32'd7);
        chk("ovr_err", {31'd0, err_overrun}, 32'd1);
      end
    end
    chk("ovr_dat_data17", dat_data, 32'h111);
    chk("ovr_dat_last17", {31'd0, dat_last}, 32'd1);
    cpl_ready = 1'b1; step(); cpl_ready = 1'b0;
    chk("ovr2_cpl_valid", {31'd0, cpl_valid}, 32'd1);
    chk("ovr2_cpl_beats", {27'd0, cpl_beats}, 32'd1);
    chk("ovr2_cpl_resp", {30'd0, cpl_resp}, 32'd0);
    chk("ovr2_err_sticky", {31'd0, err_overrun}, 32'd1);
    cpl_ready = 1'b1; step(); cpl_ready = 1'b0;
    chk("ovr_cpl_drained", {31'd0, cpl_valid}, 32'd0);

    // Completion FIFO full
    do_reset();
    dat_ready = 1'b1;
    for (int k = 1; k <= 4; k++) send_beat(4'(k), 32'h200 + 32'(k), 2'd0, 1'b1);
    chk("cfull_rready_low", {31'd0, rready}, 32'd0);
    rvalid = 1'b1; rid = 4'd5; rdata = 32'h205; rresp = 2'd0; rlast = 1'b1;
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("cfull_rready_back", {31'd0, rready}, 32'd1);
    chk("cfull_head_after_pop", {28'd0, cpl_id}, 32'd2);
    step();
    rvalid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("cfull_valid_%0d", k), {31'd0, cpl_valid}, 32'd1);
      chk($sformatf("cfull_id_%0d", k), {28'd0, cpl_id}, 32'(k));
      cpl_ready = 1'b1; step(); cpl_ready = 1'b0;
    end
    chk("cfull_drained", {31'd0, cpl_valid}, 32'd0);

    // Beat FIFO full, then random dat_ready against a queue model
    do_reset();
    cpl_ready = 1'b1;
    q.delete();
    for (int k = 0; k < 16; k++) begin
      send_beat(4'd2, 32'(k), 2'd0, (k == 15));
      q.push_back({32'(k), (k == 15)});
    end
    chk("dfull_rready_low", {31'd0, rready}, 32'd0);
    j = 0;
    for (int cyc = 0; cyc < 2000 && !(j == 60 && q.size() == 0); cyc++) begin
      chk("rand_rready", {31'd0, rready}, {31'd0, (q.size() < 16)});
      rvalid = (j < 60); rid = 4'd6; rresp = 2'd0;
      rdata = 32'h1000 + 32'(j); rlast = ((j % 4) == 3);
      dat_ready = 1'($urandom_range(0, 1));
      acc = rvalid && (q.size() < 16);
      pop = dat_ready && (q.size() != 0);
      step();
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back({rdata, rlast});
        j++;
      end
      chk("rand_dat_valid", {31'd0, dat_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        chk("rand_dat_data", dat_data, q[0][32:1]);
        chk("rand_dat_last", {31'd0, dat_last}, {31'd0, q[0][0]});
      end
    end
    chk("rand_all_beats", 32'(j), 32'd60);
    rvalid = 1'b0; dat_ready = 1'b0; cpl_ready = 1'b0;

    // Reset after 3 of 8 beats, then a fresh 2-beat burst
    do_reset();
    for (int k = 0; k < 3; k++) send_beat(4'd9, 32'h300 + 32'(k), 2'd1, 1'b0);
    do_reset();
    send_beat(4'd4, 32'h55, 2'd0, 1'b0);
    send_beat(4'd4, 32'h66, 2'd1, 1'b1);
    chk("mrst_dat_valid", {31'd0, dat_valid}, 32'd1);
    chk("mrst_dat_data", dat_data, 32'h55);
    chk("mrst_dat_last", {31'd0, dat_last}, 32'd0);
    chk("mrst_cpl_valid", {31'd0, cpl_valid}, 32'd1);
    chk("mrst_cpl_id", {28'd0, cpl_id}, 32'd4);
    chk("mrst_cpl_beats", {27'd0, cpl_beats}, 32'd2);
    chk("mrst_cpl_resp", {30'd0, cpl_resp}, 32'd1);
    chk("mrst_err", {31'd0, err_overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
